data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port.
- The MEM stage is the initiator. It presents a load/store request; this block accepts it and services it after a programmable wait latency. It then returns data and a one-cycle acknowledge.
- Busy is the stall source that freezes the pipeline while an access is outstanding.
- Supports byte, halfword and word accesses, with sign/zero extension on loads and alignment checking.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, wait cycles between accept and Ack; legal range 0..15.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  request strobe from the MEM stage.
- MemRead  input  1  request is a load.
- MemWrite  input  1  request is a store.
- Address  input  32  byte address.
- WriteData  input  32  store data; the active lane is taken from the low bits, right-justified.
- Size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
- SignExt  input  1  load extension: 1 sign-extend, 0 zero-extend.
- ReadData  output  32  load result, extended to 32 bits.
- Ack  output  1  one-cycle completion pulse.
- Busy  output  1  access outstanding; the pipeline must stall while Busy is high.
- Err  output  1  completed access was rejected; valid with Ack.

Behaviour:
- Reset:
  - State goes to IDLE; wait counter cleared.
  - Ack=0, Busy=0, Err=0, ReadData=0.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - A request is accepted on the edge where Req=1 and exactly one of MemRead/MemWrite is 1.
  - On accept, latch Address, WriteData, Size, SignExt and direction; load counter with LATENCY.
  - Go to WAIT if LATENCY>0, else go to RESP.
  - Req=1 with MemRead=MemWrite=0 is a no-op: no accept, no Ack.
  - Req=1 with MemRead=MemWrite=1 is accepted and completes as an error.
- WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 1.
- RESP:
  - On the edge leaving RESP, perform the access, register ReadData/Err, pulse Ack high for the next cycle, and return to IDLE.
  - A new request may be accepted on the edge after the Ack cycle; Ack and accept never share an edge.
- Timing: accept edge at cycle T. Ack is high in cycle T+2+LATENCY (LATENCY=2 gives Ack 4 cycles after accept).
- Busy is registered. It is high from cycle T+1 through cycle T+1+LATENCY, and low in the Ack cycle, so the pipeline advances on the Ack edge.
- Requests arriving while Busy is high are ignored. The initiator holds inputs stable, but the block uses latched copies only.
- Addressing:
  - Word index = Address[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap.
  - Little-endian lanes: offset 0 is bits [7:0]; halfword offset 2 is bits [31:16].
- Error conditions (Err=1 with Ack, ReadData=0, no array write):
  - Size=11.
  - Halfword with Address[0]=1.
  - Word with Address[1:0]≠0.
  - MemRead and MemWrite both set.
- Stores:
  - Byte store modifies only the addressed lane.
  - Halfword store modifies only the two addressed lanes.
  - Word store modifies all four lanes.
  - ReadData is unchanged on stores.
  - Store completes with Err=0.
- Loads: the selected lane(s) are extended per SignExt. A load issued immediately after a store to the same word returns the stored value.
- ReadData holds its value until the next load Ack or Reset.
- Reset in WAIT or RESP aborts the access: no Ack is issued, and a pending store is not written.

Test Plan:
- Word store 0x11223344 to 0x40, then word load 0x40 (LATENCY=2):
  - Each access gives Ack exactly 4 cycles after accept, with Busy high for 3 cycles before it.
  - Load returns 0x11223344 with Err=0.
- Byte store 0xAA to 0x42, then word load 0x40 → 0x11AA3344.
  - Byte load 0x43 with SignExt=1 → 0x00000011.
  - Store 0x80 to 0x41; byte load 0x41 with SignExt=1 → 0xFFFFFF80, with SignExt=0 → 0x00000080.
- Halfword load 0x41 → Ack with Err=1 and ReadData=0.
  - Word store to 0x42 → Err=1; word 0x40 unchanged.
  - Size=11 → Err=1.
- Pulse Req at cycle T+1 while Busy → no second Ack and no memory change.
  - Req with MemRead=MemWrite=0 → no Ack ever.
- Reset asserted during WAIT of a word store 0xDEADBEEF to 0x80 → no Ack, all outputs 0; a later load of 0x80 returns the prior contents.
- With DEPTH_WORDS=1024: word store 0xCAFEF00D to 0x1040, then load 0x0040 → 0xCAFEF00D (wrap).
  - With LATENCY=0: Ack 2 cycles after accept.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store, waits LATENCY
// cycles, then performs the access and returns data with a one-cycle Ack.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic [1:0]  Size,
   input  logic        SignExt,
   output logic [31:0] ReadData,
   output logic        Ack,
   output logic        Busy,
   output logic        Err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [1:0]      size_q, size_d;
   logic            sext_q, sext_d;
   logic            read_q, read_d;
   logic            write_q, write_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;

   logic [31:0]     mem_array [DEPTH_WORDS];
   logic [AW-1:0]   word_idx;
   logic [31:0]     cur_word;
   logic [31:0]     byte_shift;
   logic [31:0]     half_shift;
   logic [31:0]     load_val;
   logic [31:0]     wr_word;
   logic [3:0]      byte_en;
   logic            acc_err;
   logic            mem_we;
   logic            unused_addr_bits;

   // Upper address bits are deliberately dropped so addresses wrap.
   assign unused_addr_bits = ^Address[31:AW+2];

   assign word_idx   = addr_q[AW+1:2];
   assign cur_word   = mem_array[word_idx];
   assign byte_shift = cur_word >> {addr_q[1:0], 3'b000};
   assign half_shift = cur_word >> {addr_q[1], 4'b0000};

   always_comb begin
      acc_err  = 1'b0;
      load_val = 32'h0;
      wr_word  = wdata_q;
      byte_en  = 4'b0000;
      if (read_q && write_q) acc_err = 1'b1;
      case (size_q)
         2'b00: begin
            load_val = sext_q ? {{24{byte_shift[7]}}, byte_shift[7:0]}
                              : {24'h0, byte_shift[7:0]};
            wr_word  = {4{wdata_q[7:0]}};
            byte_en  = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            if (addr_q[0]) acc_err = 1'b1;
            load_val = sext_q ? {{16{half_shift[15]}}, half_shift[15:0]}
                              : {16'h0, half_shift[15:0]};
            wr_word  = {2{wdata_q[15:0]}};
            byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
            load_val = cur_word;
            wr_word  = wdata_q;
            byte_en  = 4'b1111;
         end
         default: acc_err = 1'b1;
      endcase
   end

   assign mem_we = (state_q == RESP) && write_q && !acc_err;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sext_d  = sext_q;
      read_d  = read_q;
      write_d = write_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Req && (MemRead || MemWrite)) begin
               addr_d  = Address[AW+1:0];
               wdata_d = WriteData;
               size_d  = Size;
               sext_d  = SignExt;
               read_d  = MemRead;
               write_d = MemWrite;
               cnt_d   = LAT;
               state_d = (LAT == 4'd0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
            ack_d   = 1'b1;
            err_d   = acc_err;
            if (acc_err) rdata_d = 32'h0;
            else if (read_q) rdata_d = load_val;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         rdata_q <= 32'h0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         read_q  <= read_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // A reset landing on the completion edge must suppress the pending store.
   always_ff @(posedge Clk) begin
      if (!Reset && mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem_array[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

   assign ReadData = rdata_q;
   assign Ack      = ack_q;
   assign Busy     = busy_q;
   assign Err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: two responders (LATENCY=2 and LATENCY=0) share one stimulus
// stream and are checked against hand-computed results.
module tb_data_mem_responder;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] rdata2, rdata0;
   logic        ack2, ack0, busy2, busy0, err2, err0;

   int n_cmp  = 0;
   int n_fail = 0;

   vec_t vecs [21];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_l2 (
      .Clk(clk), .Reset(reset), .Req(req), .MemRead(mem_read), .MemWrite(mem_write),
      .Address(address), .WriteData(write_data), .Size(size), .SignExt(sign_ext),
      .ReadData(rdata2), .Ack(ack2), .Busy(busy2), .Err(err2)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_l0 (
      .Clk(clk), .Reset(reset), .Req(req), .MemRead(mem_read), .MemWrite(mem_write),
      .Address(address), .WriteData(write_data), .Size(size), .SignExt(sign_ext),
      .ReadData(rdata0), .Ack(ack0), .Busy(busy0), .Err(err0)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic dropRequest();
      req       = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   // Counts Ack and Busy cycles on both responders over a fixed window.
   task automatic countWindow(output int na2, output int na0, output int nb2, output int nb0);
      na2 = 0; na0 = 0; nb2 = 0; nb0 = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (ack2) na2++;
         if (ack0) na0++;
         if (busy2) nb2++;
         if (busy0) nb0++;
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      int lat2, lat0, nb2, nb0, na2, na0;
      logic [31:0] rd2, rd0;
      logic er2, er0;
      lat2 = 0; lat0 = 0; nb2 = 0; nb0 = 0; na2 = 0; na0 = 0;
      rd2 = 32'hx; rd0 = 32'hx; er2 = 1'bx; er0 = 1'bx;
      @(negedge clk);
      req        = 1'b1;
      mem_read   = v.rd;
      mem_write  = v.wr;
      address    = v.addr;
      write_data = v.wdata;
      size       = v.size;
      sign_ext   = v.sext;
      @(posedge clk);
      #1 dropRequest();
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (busy2) nb2++;
         if (busy0) nb0++;
         if (ack2) begin
            na2++;
            if (lat2 == 0) begin lat2 = k; rd2 = rdata2; er2 = err2; end
         end
         if (ack0) begin
            na0++;
            if (lat0 == 0) begin lat0 = k; rd0 = rdata0; er0 = err0; end
         end
      end
      checkOutput({tag, " L2 ack latency"}, 32'(lat2), 32'd4);
      checkOutput({tag, " L0 ack latency"}, 32'(lat0), 32'd2);
      checkOutput({tag, " L2 busy cycles"}, 32'(nb2), 32'd3);
      checkOutput({tag, " L0 busy cycles"}, 32'(nb0), 32'd1);
      checkOutput({tag, " L2 ack count"}, 32'(na2), 32'd1);
      checkOutput({tag, " L0 ack count"}, 32'(na0), 32'd1);
      checkOutput({tag, " L2 ReadData"}, rd2, v.exp_rdata);
      checkOutput({tag, " L0 ReadData"}, rd0, v.exp_rdata);
      checkOutput({tag, " L2 Err"}, 32'(er2), 32'(v.exp_err));
      checkOutput({tag, " L0 Err"}, 32'(er0), 32'(v.exp_err));
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, " L2 Ack"}, 32'(ack2), 32'd0);
      checkOutput({tag, " L0 Ack"}, 32'(ack0), 32'd0);
      checkOutput({tag, " L2 Busy"}, 32'(busy2), 32'd0);
      checkOutput({tag, " L0 Busy"}, 32'(busy0), 32'd0);
      checkOutput({tag, " L2 Err"}, 32'(err2), 32'd0);
      checkOutput({tag, " L0 Err"}, 32'(err0), 32'd0);
      checkOutput({tag, " L2 ReadData"}, rdata2, 32'h0);
      checkOutput({tag, " L0 ReadData"}, rdata0, 32'h0);
   endtask

   initial begin
      int na2, na0, nb2, nb0;
      vec_t v;

      //             rd    wr    addr          wdata         size   sext  exp_rdata     err
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b10, 1'b0, 32'h1122_3344, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0042, 32'h0000_00AA, 2'b00, 1'b0, 32'h1122_3344, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b10, 1'b0, 32'h11AA_3344, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_0043, 32'h0,         2'b00, 1'b1, 32'h0000_0011, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_0041, 32'h0000_0080, 2'b00, 1'b0, 32'h0000_0011, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0041, 32'h0,         2'b00, 1'b1, 32'hFFFF_FF80, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0041, 32'h0,         2'b00, 1'b0, 32'h0000_0080, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0041, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0042, 32'h5555_5555, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b10, 1'b0, 32'h11AA_8044, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0,         2'b10, 1'b0, 32'h0000_0000, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b10, 1'b0, 32'h11AA_8044, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0102_0304, 2'b10, 1'b0, 32'h11AA_8044, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 32'h0000_0046, 32'h1234_BEEF, 2'b01, 1'b0, 32'h11AA_8044, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         2'b10, 1'b0, 32'hBEEF_0304, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 32'h0000_0046, 32'h0,         2'b01, 1'b1, 32'hFFFF_BEEF, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         2'b01, 1'b0, 32'h0000_0304, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 32'h0000_1040, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0304, 1'b0};
      vecs[20] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0};

      reset      = 1'b1;
      address    = 32'h0;
      write_data = 32'h0;
      size       = 2'b00;
      sign_ext   = 1'b0;
      dropRequest();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkQuiet("reset");
      reset = 1'b0;

      for (int i = 0; i < 21; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      v = '{1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0};
      applyStimulus(v, "seed80");

      // Second request pulsed one cycle after accept must be ignored.
      @(negedge clk);
      req = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
      address = 32'h0000_0040; size = 2'b10;
      @(posedge clk);
      #1;
      req = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
      address = 32'h0000_0080; write_data = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 dropRequest();
      countWindow(na2, na0, nb2, nb0);
      checkOutput("busyreq L2 ack count", 32'(na2), 32'd1);
      checkOutput("busyreq L0 ack count", 32'(na0), 32'd1);
      v = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b0};
      applyStimulus(v, "after_busyreq");

      // Request with neither direction set is a no-op.
      @(negedge clk);
      req = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      @(posedge clk);
      #1 dropRequest();
      countWindow(na2, na0, nb2, nb0);
      checkOutput("noop L2 ack count", 32'(na2), 32'd0);
      checkOutput("noop L0 ack count", 32'(na0), 32'd0);
      checkOutput("noop L2 busy cycles", 32'(nb2), 32'd0);
      checkOutput("noop L0 busy cycles", 32'(nb0), 32'd0);

      // Reset during the wait aborts a pending store.
      @(negedge clk);
      req = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
      address = 32'h0000_0080; write_data = 32'hDEAD_BEEF; size = 2'b10;
      @(posedge clk);
      #1 dropRequest();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkQuiet("abort");
      reset = 1'b0;
      countWindow(na2, na0, nb2, nb0);
      checkOutput("abort L2 ack count", 32'(na2), 32'd0);
      checkOutput("abort L0 ack count", 32'(na0), 32'd0);
      v = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b0};
      applyStimulus(v, "after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
